uart_tx: RTL and testbench

- Serial transmitter for the UART subsystem; drives the serial line that the UART receiver samples on its `in` port.
- Accepts bytes over a valid/ready handshake and serialises each as one frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Frame format is set through the same c_valid/c_addr/c_data/c_ready config interface and register map as the receiver, so both ends can be configured identically.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_baud_cnt.sv | 43 ++++
 rtl/uart_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: config register map, parity encodings, transmitter
// state encoding and the default bit period. Used by uart_tx and uart_baud_cnt.
package uart_pkg;

    // Clock cycles per serial bit (16x oversampling on the receive side).
    localparam int UART_BIT_CLKS = 16;

    // Data bits per frame; fixed.
    localparam int UART_DATA_W = 8;

    // Config register addresses, common to transmitter and receiver.
    localparam logic [3:0] UART_ADDR_PARITY = 4'h5;
    localparam logic [3:0] UART_ADDR_STOP   = 4'h6;

    // Parity mode encodings held in the parity config register.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_t;

    // Transmitter frame sequencer states.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity bit sent for a byte under the given mode. PAR_NONE returns 0,
    // but the sequencer never emits a parity bit in that mode.
    function automatic logic parity_bit(input parity_mode_t mode,
                                        input logic [UART_DATA_W-1:0] data);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. Counts 0..BIT_CLKS-1 while enabled and wraps; tick_o is
// high during the last cycle of each bit period. clr_i holds the count at 0
// so the first period after release is a full BIT_CLKS cycles long.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int BIT_CLKS = UART_BIT_CLKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_MAX);

    // Next count: clear wins, otherwise advance and wrap on the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Serialises bytes as start, 8 data bits LSB first,
// optional parity, then 1 or 2 stop bits. Frame format comes from the
// shared config register map (parity at 0x5, stop bits at 0x6).
//
// Build option UART_TX_FIFO_EN: when defined the single holding register is
// replaced by a 4-entry FIFO; otherwise one byte can be buffered.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and a writer keeps valid (and its
// data) stable until that edge. This holds for in_valid/in_ready and for
// c_valid/c_ready.
//
// Note: rst_n is an active-high synchronous reset despite its name.
// tx is registered, so the line follows the state by one cycle and is
// glitch-free; the first start-bit cycle is two edges after acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CLKS = UART_BIT_CLKS,
    parameter int DATA_W   = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              c_valid,
    input  logic [3:0]        c_addr,
    input  logic [7:0]        c_data,
    output logic              c_ready,
    output logic              tx,
    output logic              busy,
    output tx_state_t         state_o
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;

    parity_mode_t      parity_mode_q;
    logic              stop2_q;

    logic              bit_tick;
    logic              accept;
    logic              pop;
    logic              buf_empty;
    logic [DATA_W-1:0] buf_dout;
    logic              cfg_we;

    assign accept  = in_valid && in_ready;
    assign c_ready = (state_q == TX_IDLE) && buf_empty;
    assign cfg_we  = c_valid && c_ready;
    assign busy    = (state_q != TX_IDLE);
    assign tx      = tx_q;
    assign state_o = state_q;

    // Bit timer runs in every non-idle state and is held at zero in IDLE.
    uart_baud_cnt #(
        .BIT_CLKS (BIT_CLKS)
    ) u_baud (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .clr_i  (state_q == TX_IDLE),
        .en_i   (state_q != TX_IDLE),
        .tick_o (bit_tick)
    );

`ifdef UART_TX_FIFO_EN
    logic [DATA_W-1:0] fifo_mem_q [4];
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic [2:0]        count_q;

    assign in_ready  = (count_q != 3'd4);
    assign buf_empty = (count_q == 3'd0);
    assign buf_dout  = fifo_mem_q[rd_ptr_q];

    // Circular FIFO: write on accept, read on pop; both at once keep count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                fifo_mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;

    assign in_ready  = !hold_full_q;
    assign buf_empty = !hold_full_q;
    assign buf_dout  = hold_q;

    // One-entry holding register: filled on accept, emptied on pop.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (accept) begin
            hold_q      <= in_data;
            hold_full_q <= 1'b1;
        end else if (pop) begin
            hold_full_q <= 1'b0;
        end
    end
`endif

    // Config registers; writes only land while idle with nothing buffered,
    // so a frame never sees its format change part way through.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            parity_mode_q <= PAR_NONE;
            stop2_q       <= 1'b0;
        end else if (cfg_we) begin
            if (c_addr == UART_ADDR_PARITY) begin
                parity_mode_q <= parity_mode_t'(c_data[1:0]);
            end
            if (c_addr == UART_ADDR_STOP) begin
                stop2_q <= c_data[0];
            end
        end
    end

    // Frame sequencer next state, shift/parity loading and line level.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        pop        = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!buf_empty) begin
                    pop        = 1'b1;
                    shift_d    = buf_dout;
                    par_d      = parity_bit(parity_mode_q, buf_dout);
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    state_d    = TX_START;
                end
            end

            TX_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    state_d = TX_DATA;
                end
            end

            TX_DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (parity_mode_q != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end
                end
            end

            TX_PARITY: begin
                tx_d = par_q;
                if (bit_tick) begin
                    state_d = TX_STOP;
                end
            end

            TX_STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        if (!buf_empty) begin
                            // Back-to-back: next start bit follows with no gap.
                            pop       = 1'b1;
                            shift_d   = buf_dout;
                            par_d     = parity_bit(parity_mode_q, buf_dout);
                            bit_idx_d = 3'd0;
                            state_d   = TX_START;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Sequencer registers and registered line output.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Expected line levels are queued per serial bit
// (16 samples each) and compared as the frame is observed on the falling edge.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BC    = 16;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic       tx;
    logic       busy;
    tx_state_t  state_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int e_acc = 0;

    logic [15:0] exp_q[$];

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .c_valid  (c_valid),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .tx       (tx),
        .busy     (busy),
        .state_o  (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Queue expected bit levels of one frame; parity -1 means no parity bit.
    task automatic add_frame(input logic [7:0] d, input int par, input int nstop);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i] ? 16'hFFFF : 16'h0000);
        if (par >= 0) exp_q.push_back((par != 0) ? 16'hFFFF : 16'h0000);
        for (int i = 0; i < nstop; i++) exp_q.push_back(16'hFFFF);
    endtask

    // Called at the falling edge right after the accepting edge. Compares
    // every queued bit and the total number of busy cycles.
    task automatic run_levels(input string tag);
        int          n;
        int          busy_cnt;
        logic [15:0] vec;
        n        = exp_q.size();
        busy_cnt = 0;
        @(negedge clk);
        check({tag, "_pre"}, tx, 1);
        busy_cnt += busy;
        for (int l = 0; l < n; l++) begin
            for (int k = 0; k < BC; k++) begin
                @(negedge clk);
                vec[k] = tx;
                busy_cnt += busy;
            end
            check($sformatf("%s_bit%0d", tag, l), vec, exp_q.pop_front());
        end
        repeat (2) begin
            @(negedge clk);
            busy_cnt += busy;
        end
        check({tag, "_post"}, tx, 1);
        check({tag, "_busy"}, busy_cnt, n * BC);
    endtask

    // Offer a byte; returns at the falling edge after the accepting edge.
    task automatic send_byte(input logic [7:0] d, output int waits);
        in_data  = d;
        in_valid = 1'b1;
        waits    = 0;
        while (!in_ready && waits < LIMIT) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= LIMIT) check("accept_timeout", waits, 0);
        @(negedge clk);
        in_valid = 1'b0;
        e_acc    = cyc;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        int w;
        c_addr  = a;
        c_data  = d;
        c_valid = 1'b1;
        w       = 0;
        while (!c_ready && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        if (w >= LIMIT) check("cfg_timeout", w, 0);
        @(negedge clk);
        c_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int w;
        w = 0;
        while (!c_ready && w < limit) begin
            @(negedge clk);
            w++;
        end
        check(tag, c_ready, 1);
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        int w;
        int w2;
        int e0;
        rst_n    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        c_valid  = 1'b0;
        c_addr   = '0;
        c_data   = '0;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_c_ready", c_ready, 1);
        check("rst_state", 32'(state_o), 32'(TX_IDLE));
        rst_n = 1'b0;
        @(negedge clk);

        // Unmapped address is ignored; 0xA5 no parity, one stop
        cfg_write(4'h3, 8'hFF);
        send_byte(8'hA5, w);
        add_frame(8'hA5, -1, 1);
        run_levels("a5");

        // Config written mid-frame waits for idle, applies to the next frame
        send_byte(8'h07, w);
        e0 = e_acc;
        add_frame(8'h07, -1, 1);
        fork
            run_levels("cfg_busy_frame");
            begin
                repeat (50) @(negedge clk);
                c_addr  = UART_ADDR_PARITY;
                c_data  = 8'h01;
                c_valid = 1'b1;
                check("cfg_blocked", c_ready, 0);
                w2 = 0;
                while (!c_ready && w2 < LIMIT) begin
                    @(negedge clk);
                    w2++;
                end
                check("cfg_ready_at", cyc - e0, 161);
                check("cfg_ready_busy", busy, 0);
                @(negedge clk);
                c_valid = 1'b0;
            end
        join

        // 0x07 has three set bits: even -> 1, odd -> 0, mark -> 1
        send_byte(8'h07, w);
        add_frame(8'h07, 1, 1);
        run_levels("even");
        cfg_write(UART_ADDR_PARITY, 8'h02);
        send_byte(8'h07, w);
        add_frame(8'h07, 0, 1);
        run_levels("odd");
        cfg_write(UART_ADDR_PARITY, 8'h03);
        send_byte(8'h07, w);
        add_frame(8'h07, 1, 1);
        run_levels("mark");
        cfg_write(UART_ADDR_PARITY, 8'h00);

        // Two stop bits
        cfg_write(UART_ADDR_STOP, 8'h01);
        send_byte(8'h00, w);
        add_frame(8'h00, -1, 2);
        run_levels("stop2");
        cfg_write(UART_ADDR_STOP, 8'h00);

        // Back-to-back frames with no idle gap
        send_byte(8'h55, w);
        add_frame(8'h55, -1, 1);
        add_frame(8'hAA, -1, 1);
        fork
            send_byte(8'hAA, w2);
            run_levels("b2b");
        join

        // Buffer depth
`ifdef UART_TX_FIFO_EN
        send_byte(8'h11, w);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h20 + 8'(i), w);
            check($sformatf("fifo_nostall%0d", i), w, 0);
        end
        check("fifo_stall", in_ready, 0);
        wait_drain("fifo_drain", 6 * 200);
`else
        send_byte(8'h11, w);
        check("hold_full", in_ready, 0);
        check("hold_cready", c_ready, 0);
        wait_drain("hold_drain", 400);
`endif

        // Reset during DATA with a byte buffered and non-default config
        cfg_write(UART_ADDR_PARITY, 8'h01);
        cfg_write(UART_ADDR_STOP, 8'h01);
        send_byte(8'h3C, w);
        send_byte(8'h99, w);
        repeat (38) @(negedge clk);
        check("mid_state", 32'(state_o), 32'(TX_DATA));
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_tx", tx, 1);
        check("mrst_busy", busy, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_c_ready", c_ready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_idle", busy, 0);

        // Defaults restored: no parity, one stop, nothing stale sent after
        send_byte(8'h07, w);
        add_frame(8'h07, -1, 1);
        run_levels("post_rst");
        repeat (20) @(negedge clk);
        check("no_stale", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
